// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: shared encodings for the writeback stage.
//   - dsize encodings (load width)
//   - fpoint encodings (register-file bank select)
//   - writeback FSM state type
//   - MEM/WB pipeline register layout
package wb_stage_pkg;

   localparam logic [1:0] DSZ_BYTE = 2'b00;
   localparam logic [1:0] DSZ_HALF = 2'b01;
   localparam logic [1:0] DSZ_WORD = 2'b10;

   localparam logic [1:0] FP_INT    = 2'b00;
   localparam logic [1:0] FP_SINGLE = 2'b01;
   localparam logic [1:0] FP_DOUBLE = 2'b10;

   // WB_LO writes the (first) word, WB_HI writes the odd half of a double
   typedef enum logic {WB_LO, WB_HI} wb_state_e;

   typedef struct packed {
      logic        valid;
      logic        regwrite;
      logic        mem2reg;
      logic        jal;
      logic        loadext;
      logic [1:0]  dsize;
      logic [1:0]  fpoint;
      logic [4:0]  rd;
      logic [1:0]  addrlow;
      logic [31:0] aluresult;
      logic [31:0] memdata;
      logic [31:0] memdata_hi;
      logic [31:0] link;
   } memwb_t;

endpackage

// File: rtl/load_align.sv
// load_align: big-endian load lane extraction and extension (combinational).
//   memdata  in  32  loaded word
//   addrlow  in  2   effective address bits [1:0]
//   dsize    in  2   load width (11 behaves as word)
//   loadext  in  1   1 = sign-extend sub-word, 0 = zero-extend
//   value    out 32  extended load value
module load_align
   import wb_stage_pkg::*;
(
   input  logic [31:0] memdata,
   input  logic [1:0]  addrlow,
   input  logic [1:0]  dsize,
   input  logic        loadext,
   output logic [31:0] value
);

   logic [7:0]  lane_byte;
   logic [15:0] lane_half;

   always_comb begin
      lane_byte = 8'h00;
      unique case (addrlow)
         2'd0: lane_byte = memdata[31:24];
         2'd1: lane_byte = memdata[23:16];
         2'd2: lane_byte = memdata[15:8];
         2'd3: lane_byte = memdata[7:0];
         default: lane_byte = 8'h00;
      endcase

      // addrlow[0] is ignored for halfwords
      lane_half = addrlow[1] ? memdata[15:0] : memdata[31:16];

      case (dsize)
         DSZ_BYTE: value = {{24{loadext & lane_byte[7]}}, lane_byte};
         DSZ_HALF: value = {{16{loadext & lane_half[15]}}, lane_half};
         DSZ_WORD: value = memdata;
         default:  value = memdata;
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: pipeline writeback stage, write side of the register file.
//   clk, rst_n        clock, asynchronous active-low reset
//   d_*               MEM-stage result fields, captured into the MEM/WB register
//   rw/busW           register file write index / data
//   wrenable          register file write strobe
//   fpoint            register file bank select (00 int, 01 single, 10 double)
//   wb_busy           stall request upstream while the first word of a double is written
module wb_stage
   import wb_stage_pkg::*;
#(
   parameter int unsigned LINK_REG = 31
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        d_valid,
   input  logic        d_regwrite,
   input  logic        d_mem2reg,
   input  logic        d_jal,
   input  logic        d_loadext,
   input  logic [1:0]  d_dsize,
   input  logic [1:0]  d_fpoint,
   input  logic [4:0]  d_rd,
   input  logic [1:0]  d_addrlow,
   input  logic [31:0] d_aluresult,
   input  logic [31:0] d_memdata,
   input  logic [31:0] d_memdata_hi,
   input  logic [31:0] d_link,
   output logic [4:0]  rw,
   output logic [31:0] busW,
   output logic        wrenable,
   output logic [1:0]  fpoint,
   output logic        wb_busy
);

   localparam logic [4:0] LinkIdx = 5'(LINK_REG);

   memwb_t    memwb_d, memwb_q;
   wb_state_e state_d, state_q;
   logic [31:0] load_val;
   logic        is_double;

   always_comb begin
      memwb_d            = '0;
      memwb_d.valid      = d_valid;
      memwb_d.regwrite   = d_regwrite;
      memwb_d.mem2reg    = d_mem2reg;
      memwb_d.jal        = d_jal;
      memwb_d.loadext    = d_loadext;
      memwb_d.dsize      = d_dsize;
      memwb_d.fpoint     = d_fpoint;
      memwb_d.rd         = d_rd;
      memwb_d.addrlow    = d_addrlow;
      memwb_d.aluresult  = d_aluresult;
      memwb_d.memdata    = d_memdata;
      memwb_d.memdata_hi = d_memdata_hi;
      memwb_d.link       = d_link;
   end

   // The register holds while the first word of a double is being written
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         memwb_q <= '0;
         state_q <= WB_LO;
      end else begin
         if (!wb_busy) begin
            memwb_q <= memwb_d;
         end
         state_q <= state_d;
      end
   end

   load_align u_load_align (
      .memdata (memwb_q.memdata),
      .addrlow (memwb_q.addrlow),
      .dsize   (memwb_q.dsize),
      .loadext (memwb_q.loadext),
      .value   (load_val)
   );

   // jal takes priority and always writes an integer register, so it never splits
   assign is_double = memwb_q.valid & memwb_q.regwrite & ~memwb_q.jal &
                      (memwb_q.fpoint == FP_DOUBLE);

   always_comb begin
      state_d  = state_q;
      rw       = memwb_q.rd;
      busW     = memwb_q.aluresult;
      fpoint   = FP_INT;
      wrenable = 1'b0;
      wb_busy  = 1'b0;

      case (state_q)
         WB_LO: begin
            if (is_double) begin
               rw       = memwb_q.rd & 5'b11110;
               busW     = memwb_q.mem2reg ? memwb_q.memdata : memwb_q.aluresult;
               fpoint   = FP_DOUBLE;
               wrenable = 1'b1;
               wb_busy  = 1'b1;
               state_d  = WB_HI;
            end else begin
               if (memwb_q.jal) begin
                  rw     = LinkIdx;
                  busW   = memwb_q.link;
                  fpoint = FP_INT;
               end else begin
                  rw     = memwb_q.rd;
                  busW   = memwb_q.mem2reg ? load_val : memwb_q.aluresult;
                  // reserved encoding 11 behaves as integer
                  fpoint = ((memwb_q.fpoint == FP_SINGLE) || (memwb_q.fpoint == FP_DOUBLE)) ?
                           memwb_q.fpoint : FP_INT;
               end
               // integer r0 is hardwired; FP f0 is a real register
               wrenable = memwb_q.valid & memwb_q.regwrite &
                          ~((fpoint == FP_INT) && (rw == 5'd0));
            end
         end
         WB_HI: begin
            rw       = memwb_q.rd | 5'b00001;
            busW     = memwb_q.memdata_hi;
            fpoint   = FP_DOUBLE;
            wrenable = 1'b1;
            state_d  = WB_LO;
         end
         default: state_d = WB_LO;
      endcase
   end

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: scoreboard bench for wb_stage. The driver pushes the expected
// register-file write for the cycle it should appear in; a negedge monitor pops
// and compares independently.
module tb_wb_stage;
   import wb_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        d_valid, d_regwrite, d_mem2reg, d_jal, d_loadext;
   logic [1:0]  d_dsize, d_fpoint, d_addrlow;
   logic [4:0]  d_rd;
   logic [31:0] d_aluresult, d_memdata, d_memdata_hi, d_link;
   logic [4:0]  rw;
   logic [31:0] busW;
   logic        wrenable, wb_busy;
   logic [1:0]  fpoint;

   wb_stage #(.LINK_REG(31)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .d_valid      (d_valid),
      .d_regwrite   (d_regwrite),
      .d_mem2reg    (d_mem2reg),
      .d_jal        (d_jal),
      .d_loadext    (d_loadext),
      .d_dsize      (d_dsize),
      .d_fpoint     (d_fpoint),
      .d_rd         (d_rd),
      .d_addrlow    (d_addrlow),
      .d_aluresult  (d_aluresult),
      .d_memdata    (d_memdata),
      .d_memdata_hi (d_memdata_hi),
      .d_link       (d_link),
      .rw           (rw),
      .busW         (busW),
      .wrenable     (wrenable),
      .fpoint       (fpoint),
      .wb_busy      (wb_busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic        valid, regwrite, mem2reg, jal, loadext;
      logic [1:0]  dsize, fpoint;
      logic [4:0]  rd;
      logic [1:0]  addrlow;
      logic [31:0] alu, mem, mem_hi, link;
   } vec_t;

   typedef struct {
      int          cyc;
      bit          full;   // 0: only wrenable and wb_busy are checked
      logic [4:0]  rw;
      logic [31:0] busw;
      logic        we;
      logic [1:0]  fp;
      logic        busy;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];
   int    n_checks = 0;
   int    n_pass = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h, expected %h", nm, act, req);
   endtask

   task automatic chk_out(input string nm, input exp_t e);
      chk({nm, ".wrenable"}, 32'(wrenable), 32'(e.we));
      chk({nm, ".wb_busy"}, 32'(wb_busy), 32'(e.busy));
      if (e.full) begin
         chk({nm, ".rw"}, 32'(rw), 32'(e.rw));
         chk({nm, ".busW"}, busW, e.busw);
         chk({nm, ".fpoint"}, 32'(fpoint), 32'(e.fp));
      end
   endtask

   function automatic exp_t mk(input logic [4:0] r, input logic [31:0] b, input logic we,
                               input logic [1:0] fp, input logic busy);
      exp_t e;
      e.cyc = 0; e.full = 1'b1; e.rw = r; e.busw = b; e.we = we; e.fp = fp; e.busy = busy;
      return e;
   endfunction

   function automatic vec_t v_alu(input logic [4:0] rd, input logic [31:0] alu,
                                  input logic [1:0] fp);
      vec_t v;
      v = '0;
      v.valid = 1'b1; v.regwrite = 1'b1; v.rd = rd; v.alu = alu; v.fpoint = fp;
      v.dsize = DSZ_WORD; v.mem = 32'h0BAD0BAD; v.mem_hi = 32'h0BAD0BAD; v.link = 32'h0BAD0BAD;
      return v;
   endfunction

   function automatic vec_t v_load(input logic [1:0] dsz, input logic [1:0] al,
                                   input logic ext);
      vec_t v;
      v = v_alu(5'd8, 32'hCAFEF00D, FP_INT);
      v.mem2reg = 1'b1; v.dsize = dsz; v.addrlow = al; v.loadext = ext; v.mem = 32'h80FF7F01;
      return v;
   endfunction

   task automatic apply(input vec_t v);
      d_valid = v.valid; d_regwrite = v.regwrite; d_mem2reg = v.mem2reg; d_jal = v.jal;
      d_loadext = v.loadext; d_dsize = v.dsize; d_fpoint = v.fpoint; d_rd = v.rd;
      d_addrlow = v.addrlow; d_aluresult = v.alu; d_memdata = v.mem;
      d_memdata_hi = v.mem_hi; d_link = v.link;
   endtask

   // Present v for one cycle; its write is expected in the following cycle
   task automatic drive(input vec_t v, input bit has_exp, input exp_t e, input string nm);
      @(posedge clk);
      #1;
      apply(v);
      if (has_exp) begin
         e.cyc = cyc + 1;
         exp_q.push_back(e);
         name_q.push_back(nm);
      end
   endtask

   task automatic push_now(input exp_t e, input string nm);
      e.cyc = cyc;
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   // Monitor: outputs are settled by the falling edge
   always @(negedge clk) begin
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
         chk_out(name_q[0], exp_q[0]);
         void'(exp_q.pop_front());
         void'(name_q.pop_front());
      end
   end

   vec_t v, dbl, bub;
   exp_t e0, ep;

   initial begin
      bub = '0;
      apply(bub);
      e0 = mk(5'd0, 32'h0, 1'b0, FP_INT, 1'b0);
      #2;
      chk_out("reset", e0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      drive(v_alu(5'd5, 32'h12345678, FP_INT), 1,
            mk(5'd5, 32'h12345678, 1'b1, FP_INT, 1'b0), "alu_rd5");

      drive(v_load(DSZ_BYTE, 2'd0, 1'b1), 1, mk(5'd8, 32'hFFFFFF80, 1'b1, FP_INT, 1'b0), "lb_a0");
      drive(v_load(DSZ_BYTE, 2'd2, 1'b1), 1, mk(5'd8, 32'h0000007F, 1'b1, FP_INT, 1'b0), "lb_a2");
      drive(v_load(DSZ_BYTE, 2'd1, 1'b0), 1, mk(5'd8, 32'h000000FF, 1'b1, FP_INT, 1'b0), "lbu_a1");
      drive(v_load(DSZ_BYTE, 2'd3, 1'b1), 1, mk(5'd8, 32'h00000001, 1'b1, FP_INT, 1'b0), "lb_a3");
      drive(v_load(DSZ_HALF, 2'd2, 1'b0), 1, mk(5'd8, 32'h00007F01, 1'b1, FP_INT, 1'b0), "lhu_a2");
      drive(v_load(DSZ_HALF, 2'd0, 1'b1), 1, mk(5'd8, 32'hFFFF80FF, 1'b1, FP_INT, 1'b0), "lh_a0");
      drive(v_load(DSZ_HALF, 2'd1, 1'b0), 1, mk(5'd8, 32'h000080FF, 1'b1, FP_INT, 1'b0), "lhu_a1");
      drive(v_load(DSZ_WORD, 2'd0, 1'b1), 1, mk(5'd8, 32'h80FF7F01, 1'b1, FP_INT, 1'b0), "lw");

      // jal beats mem2reg and a non-integer bank
      v = v_load(DSZ_WORD, 2'd0, 1'b0);
      v.jal = 1'b1; v.rd = 5'd3; v.link = 32'h00000108; v.fpoint = FP_SINGLE;
      drive(v, 1, mk(5'd31, 32'h00000108, 1'b1, FP_INT, 1'b0), "jal");

      drive(v_alu(5'd0, 32'h00000077, FP_INT), 1,
            mk(5'd0, 32'h00000077, 1'b0, FP_INT, 1'b0), "int_r0");
      drive(v_alu(5'd0, 32'h3F800000, FP_SINGLE), 1,
            mk(5'd0, 32'h3F800000, 1'b1, FP_SINGLE, 1'b0), "fp_f0");

      // Double load into odd rd, held for the busy cycle, then an ALU op
      dbl = v_alu(5'd7, 32'h00000001, FP_DOUBLE);
      dbl.mem2reg = 1'b1; dbl.mem = 32'hAAAA0000; dbl.mem_hi = 32'h5555FFFF;
      drive(dbl, 1, mk(5'd6, 32'hAAAA0000, 1'b1, FP_DOUBLE, 1'b1), "dbl_w0");
      drive(dbl, 1, mk(5'd7, 32'h5555FFFF, 1'b1, FP_DOUBLE, 1'b0), "dbl_w1");
      drive(v_alu(5'd9, 32'hDEADBEEF, FP_INT), 1,
            mk(5'd9, 32'hDEADBEEF, 1'b1, FP_INT, 1'b0), "after_dbl");

      // Register-sourced double (FP move), even rd
      dbl = v_alu(5'd4, 32'h01020304, FP_DOUBLE);
      dbl.mem_hi = 32'h0A0B0C0D;
      drive(dbl, 1, mk(5'd4, 32'h01020304, 1'b1, FP_DOUBLE, 1'b1), "dmov_w0");
      drive(dbl, 1, mk(5'd5, 32'h0A0B0C0D, 1'b1, FP_DOUBLE, 1'b0), "dmov_w1");

      // Double without regwrite: no stall, no write
      dbl.regwrite = 1'b0;
      ep = mk(5'd0, 32'h0, 1'b0, FP_INT, 1'b0);
      ep.full = 1'b0;
      drive(dbl, 1, ep, "dbl_norw");

      // Bubbles carrying junk fields
      v = v_alu(5'd4, 32'h00000055, FP_INT);
      v.valid = 1'b0;
      for (int i = 0; i < 3; i++)
         drive(v, 1, mk(5'd4, 32'h00000055, 1'b0, FP_INT, 1'b0), $sformatf("bubble%0d", i));
      drive(bub, 1, e0, "bubble_zero");

      // Reset during the first word of a double
      dbl = v_alu(5'd11, 32'h0, FP_DOUBLE);
      dbl.mem2reg = 1'b1; dbl.mem = 32'h11112222; dbl.mem_hi = 32'h33334444;
      drive(dbl, 0, e0, "");
      @(posedge clk);
      #1;
      apply(bub);
      chk_out("rst_dbl_w0", mk(5'd10, 32'h11112222, 1'b1, FP_DOUBLE, 1'b1));
      rst_n = 1'b0;
      #1;
      chk_out("rst_async", e0);
      push_now(e0, "rst_held");
      @(posedge clk);
      #1;
      push_now(e0, "rst_edge");
      #1 rst_n = 1'b1;
      drive(bub, 1, e0, "post_rst0");
      drive(bub, 1, e0, "post_rst1");

      repeat (3) @(posedge clk);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1, "timeout");
   end

endmodule
